// File: rtl/hcordic_pkg.sv
// hcordic_pkg: shared state encoding, mode/operation codes and convergence default for the CORDIC iteration controller.
package hcordic_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT_FSM, S_FIRE, S_WAIT_ALU, S_DONE} state_e;
  localparam logic [1:0] MODE_LINEAR = 2'b00;
  localparam logic [1:0] MODE_CIRCULAR = 2'b01;
  localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;
  localparam logic OP_ROTATION = 1'b1;
  localparam logic OP_VECTORING = 1'b0;
  localparam logic [7:0] CONV_EXP_DEF = 8'h70;
  function automatic logic [7:0] exp_of(input logic [31:0] f);
    return f[30:23];
  endfunction
endpackage

// File: rtl/hcordic_iter_ctrl_if.sv
// hcordic_iter_ctrl_if: job request, FSM/ALU handshake and result bundle of the iteration controller.
interface hcordic_iter_ctrl_if;
  logic start;
  logic [1:0] mode;
  logic operation;
  logic [31:0] x_in, y_in, z_in, k_in;
  logic [31:0] x_alu, y_alu, z_alu, k_alu;
  logic done_FSM, done_ALU;
  logic [31:0] x, y, z, k;
  logic [1:0] mode_q;
  logic operation_q;
  logic enable_ALU, busy, done;
  logic [31:0] x_final, y_final, z_final, k_final;
  logic [4:0] iter_count;
  logic max_hit, timeout;
  modport slave (
    input start, mode, operation, x_in, y_in, z_in, k_in, x_alu, y_alu, z_alu, k_alu, done_FSM, done_ALU,
    output x, y, z, k, mode_q, operation_q, enable_ALU, busy, done,
    output x_final, y_final, z_final, k_final, iter_count, max_hit, timeout
  );
  modport master (
    output start, mode, operation, x_in, y_in, z_in, k_in, x_alu, y_alu, z_alu, k_alu, done_FSM, done_ALU,
    input x, y, z, k, mode_q, operation_q, enable_ALU, busy, done,
    input x_final, y_final, z_final, k_final, iter_count, max_hit, timeout
  );
endinterface

// File: rtl/hcordic_watchdog.sv
// hcordic_watchdog: wait-cycle counter; expire marks the LIMIT-th consecutive enabled cycle.
module hcordic_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
  assign expire = enable && !clear && cnt_q == W'(LIMIT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hcordic_iter_ctrl.sv
// hcordic_iter_ctrl: sequences CORDIC iterations between the angle FSM and the ALU until convergence, cap or watchdog.
module hcordic_iter_ctrl
  import hcordic_pkg::*;
#(
  parameter int MAX_ITER = 16,
  parameter int WAIT_LIMIT = 255,
  parameter logic [7:0] CONV_EXP = CONV_EXP_DEF
) (
  input logic clock,
  input logic reset,
  hcordic_iter_ctrl_if.slave io
);
  state_e state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, k_q, k_d;
  logic [31:0] xf_q, xf_d, yf_q, yf_d, zf_q, zf_d, kf_q, kf_d;
  logic [1:0] mode_lat_q, mode_lat_d;
  logic op_q, op_d, max_hit_q, max_hit_d, timeout_q, timeout_d, fsm_prev_q;
  logic [4:0] iter_q, iter_d;
  logic waiting, wd_expire, fsm_rise, converged;
  assign waiting = state_q inside {S_WAIT_FSM, S_WAIT_ALU};
  assign fsm_rise = io.done_FSM && !fsm_prev_q;
  assign converged = exp_of(op_q == OP_ROTATION ? z_q : y_q) <= CONV_EXP;
  hcordic_watchdog #(.LIMIT(WAIT_LIMIT)) u_wd (
    .clock(clock), .reset(reset), .clear(!waiting), .enable(waiting), .expire(wd_expire)
  );
  always_comb begin
    state_d = state_q;
    {x_d, y_d, z_d, k_d} = {x_q, y_q, z_q, k_q};
    {xf_d, yf_d, zf_d, kf_d} = {xf_q, yf_q, zf_q, kf_q};
    mode_lat_d = mode_lat_q;
    op_d = op_q;
    iter_d = iter_q;
    max_hit_d = max_hit_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (io.start) begin
        {x_d, y_d, z_d, k_d} = {io.x_in, io.y_in, io.z_in, io.k_in};
        mode_lat_d = io.mode;
        op_d = io.operation;
        iter_d = '0;
        max_hit_d = 1'b0;
        timeout_d = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        max_hit_d = !converged && iter_q == 5'(MAX_ITER);
        state_d = converged || max_hit_d ? S_DONE : S_WAIT_FSM;
      end
      S_WAIT_FSM: if (fsm_rise) state_d = S_FIRE;
        else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d = S_DONE;
        end
      S_FIRE: state_d = S_WAIT_ALU;
      S_WAIT_ALU: if (io.done_ALU) begin
        {x_d, y_d, z_d, k_d} = {io.x_alu, io.y_alu, io.z_alu, io.k_alu};
        iter_d = iter_q == 5'd31 ? iter_q : iter_q + 5'd1;
        state_d = S_CHECK;
      end else if (wd_expire) begin
        timeout_d = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // results are captured on entry so they are already valid while done pulses
    if (state_d == S_DONE) {xf_d, yf_d, zf_d, kf_d} = {x_q, y_q, z_q, k_q};
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      {x_q, y_q, z_q, k_q} <= '0;
      {xf_q, yf_q, zf_q, kf_q} <= '0;
      mode_lat_q <= '0;
      op_q <= 1'b0;
      iter_q <= '0;
      max_hit_q <= 1'b0;
      timeout_q <= 1'b0;
      fsm_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {x_q, y_q, z_q, k_q} <= {x_d, y_d, z_d, k_d};
      {xf_q, yf_q, zf_q, kf_q} <= {xf_d, yf_d, zf_d, kf_d};
      mode_lat_q <= mode_lat_d;
      op_q <= op_d;
      iter_q <= iter_d;
      max_hit_q <= max_hit_d;
      timeout_q <= timeout_d;
      fsm_prev_q <= io.done_FSM;
    end
  assign {io.x, io.y, io.z, io.k} = {x_q, y_q, z_q, k_q};
  assign {io.x_final, io.y_final, io.z_final, io.k_final} = {xf_q, yf_q, zf_q, kf_q};
  assign io.mode_q = mode_lat_q;
  assign io.operation_q = op_q;
  assign io.iter_count = iter_q;
  assign io.max_hit = max_hit_q;
  assign io.timeout = timeout_q;
  assign io.enable_ALU = state_q == S_FIRE;
  assign io.busy = state_q != S_IDLE;
  assign io.done = state_q == S_DONE;
endmodule

// File: tb/tb_hcordic_iter_ctrl.sv
// tb_hcordic_iter_ctrl: randomized FSM/ALU environment checked against a job-level convergence model.
module tb_hcordic_iter_ctrl;
  localparam int MAX_ITER = 16;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  hcordic_iter_ctrl_if bus();
  hcordic_iter_ctrl dut (.clock(clock), .reset(reset), .io(bus));
  int checks = 0, errors = 0;
  logic [31:0] rx[32], ry[32], rz[32], rk[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic conv(input logic op, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] v;
    v = op ? z : y;
    return v[30:23] <= 8'h70;
  endfunction

  function automatic logic [31:0] fl(input bit c);
    logic [7:0] e;
    e = c ? 8'($urandom_range(0, 112)) : 8'($urandom_range(113, 255));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.mode = 0; bus.operation = 0;
    {bus.x_in, bus.y_in, bus.z_in, bus.k_in} = '0;
    {bus.x_alu, bus.y_alu, bus.z_alu, bus.k_alu} = '0;
    bus.done_FSM = 0; bus.done_ALU = 0;
  endtask

  task automatic fill_resp(input logic op, input int conv_at);
    for (int i = 0; i < 32; i++) begin
      rx[i] = $urandom; ry[i] = $urandom; rz[i] = $urandom; rk[i] = $urandom;
      if (op) rz[i] = fl(i == conv_at - 1); else ry[i] = fl(i == conv_at - 1);
    end
  endtask

  task automatic run_job(input logic op, input logic [1:0] md, input logic [31:0] xi, yi, zi, ki,
                         input bit extra_start, input bit garbage);
    int eit = 0, fsm_at, fsm_len, alu_at = -1, ri = 0, pulses = 0, dones = 0, done_cyc = -1, starts = 0, post = 0;
    logic emax;
    logic [31:0] cx = xi, cy = yi, cz = zi, ck = ki, fx = 0, fy = 0, fz = 0, fk = 0;
    logic [4:0] fit = 0;
    logic fmax = 0, fto = 0, fop = 0;
    logic [1:0] fmd = 0;
    while (!conv(op, cy, cz) && eit < MAX_ITER) begin
      {cx, cy, cz, ck} = {rx[eit], ry[eit], rz[eit], rk[eit]};
      eit++;
    end
    emax = !conv(op, cy, cz);
    tick();
    bus.start = 1; bus.mode = md; bus.operation = op;
    {bus.x_in, bus.y_in, bus.z_in, bus.k_in} = {xi, yi, zi, ki};
    fsm_at = 2 + $urandom_range(0, 3);
    fsm_len = 1 + $urandom_range(0, 2);
    for (int c = 0; c < 3000 && post < 4; c++) begin
      if (c > 0) begin
        if (bus.enable_ALU) begin
          pulses++;
          alu_at = c + $urandom_range(1, 4);
        end
        if (bus.done) begin
          dones++;
          done_cyc = c;
          {fx, fy, fz, fk} = {bus.x_final, bus.y_final, bus.z_final, bus.k_final};
          {fit, fmax, fto, fop, fmd} = {bus.iter_count, bus.max_hit, bus.timeout, bus.operation_q, bus.mode_q};
        end
        if (done_cyc >= 0) post++;
        bus.start = extra_start && bus.busy && !bus.done && starts < 2 && $urandom_range(0, 1) == 1;
        if (bus.start) starts++;
      end
      bus.done_FSM = c >= fsm_at && c < fsm_at + fsm_len;
      {bus.x_alu, bus.y_alu, bus.z_alu, bus.k_alu} = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      bus.done_ALU = garbage && c == fsm_at;
      if (c == alu_at && ri < 32) begin
        bus.done_ALU = 1;
        {bus.x_alu, bus.y_alu, bus.z_alu, bus.k_alu} = {rx[ri], ry[ri], rz[ri], rk[ri]};
        ri++;
        fsm_at = c + 2 + $urandom_range(0, 3);
        fsm_len = 1 + $urandom_range(0, 2);
      end
      tick();
    end
    idle_inputs();
    check("done_count", dones, 1);
    check("alu_pulses", pulses, eit);
    check("iter_count", 32'(fit), eit);
    check("max_hit", fmax, emax);
    check("timeout", fto, 0);
    check("x_final", fx, cx);
    check("y_final", fy, cy);
    check("z_final", fz, cz);
    check("k_final", fk, ck);
    check("mode_q", fmd, md);
    check("operation_q", fop, op);
    if (eit == 0) check("entry_latency", done_cyc, 2);
    check("idle_after", bus.busy, 0);
  endtask

  task automatic timeout_job(input bit hold);
    int pulses = 0, en_cyc = -1, alu_cyc = -1, done_cyc = -1;
    logic [31:0] xi = $urandom, yi = $urandom, zi = fl(0), ki = $urandom;
    logic [31:0] ax = $urandom, ay = $urandom, az = fl(0), ak = $urandom, fx = 0, fz = 0;
    logic [4:0] fit = 0;
    logic fto = 0, fmax = 1;
    tick();
    bus.start = 1; bus.mode = 2'b01; bus.operation = 1;
    {bus.x_in, bus.y_in, bus.z_in, bus.k_in} = {xi, yi, zi, ki};
    for (int c = 0; c < 700 && done_cyc < 0; c++) begin
      if (c > 0) begin
        bus.start = 0;
        if (bus.enable_ALU) begin pulses++; en_cyc = c; end
        if (bus.done) begin
          done_cyc = c;
          {fx, fz, fit, fto, fmax} = {bus.x_final, bus.z_final, bus.iter_count, bus.timeout, bus.max_hit};
        end
      end
      bus.done_FSM = hold ? c >= 2 : c == 2;
      bus.done_ALU = hold && en_cyc >= 0 && c == en_cyc + 1;
      {bus.x_alu, bus.y_alu, bus.z_alu, bus.k_alu} = {ax, ay, az, ak};
      if (bus.done_ALU) alu_cyc = c;
      tick();
    end
    idle_inputs();
    check(hold ? "held_pulses" : "alu_to_pulses", pulses, 1);
    check(hold ? "held_timeout" : "alu_timeout", fto, 1);
    check(hold ? "held_max_hit" : "alu_max_hit", fmax, 0);
    check(hold ? "held_iter" : "alu_iter", 32'(fit), hold ? 1 : 0);
    check(hold ? "held_x_final" : "alu_x_final", fx, hold ? ax : xi);
    check(hold ? "held_z_final" : "alu_z_final", fz, hold ? az : zi);
    if (hold) check("held_wait_cycles", done_cyc - alu_cyc, 2 + 255);
    else check("alu_wait_cycles", done_cyc - en_cyc, 1 + 255);
  endtask

  task automatic reset_midjob();
    tick();
    bus.start = 1; bus.mode = 2'b11; bus.operation = 1;
    {bus.x_in, bus.y_in, bus.z_in, bus.k_in} = {32'($urandom) | 1, 32'h1, fl(0), 32'h1};
    tick(); bus.start = 0;
    tick(); bus.done_FSM = 1;
    tick(); bus.done_FSM = 0;
    check("rst_fire", bus.enable_ALU, 1);
    tick();
    tick();
    check("rst_busy_before", bus.busy, 1);
    #2 reset = 1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_x", bus.x, 0);
    check("rst_z", bus.z, 0);
    check("rst_finals", bus.x_final | bus.y_final | bus.z_final | bus.k_final, 0);
    check("rst_flags", {bus.mode_q, bus.operation_q, bus.iter_count, bus.max_hit, bus.timeout, bus.enable_ALU, bus.done}, 0);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    logic op;
    logic [1:0] md;
    int k;
    idle_inputs();
    tick(); tick();
    check("reset_busy", bus.busy, 0);
    check("reset_regs", bus.x | bus.y | bus.z | bus.k | bus.x_final | bus.z_final, 0);
    check("reset_flags", {bus.mode_q, bus.operation_q, bus.iter_count, bus.max_hit, bus.timeout, bus.enable_ALU, bus.done}, 0);
    @(negedge clock);
    reset = 0;
    fill_resp(1, 1);
    run_job(1, 2'b01, 32'h3F800000, 32'h12345678, 32'h38000000, 32'h3F1B74EE, 0, 0);
    fill_resp(1, 0);
    rz[0] = 32'h3C000000; rz[1] = 32'h38000000;
    run_job(1, 2'b01, 32'h3F800000, 32'h0, 32'h3F000000, 32'h3F1B74EE, 1, 1);
    fill_resp(0, 0);
    for (int i = 0; i < 32; i++) ry[i] = {1'($urandom), 8'h7E, 23'($urandom)};
    run_job(0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h0, 32'h3F9A8F44, 1, 0);
    timeout_job(1);
    timeout_job(0);
    reset_midjob();
    for (int j = 0; j < 12; j++) begin
      op = 1'($urandom);
      md = 2'($urandom_range(0, 2));
      if (md == 2'd2) md = 2'b11;
      k = $urandom_range(0, 18);
      fill_resp(op, k);
      run_job(op, md, $urandom, op ? 32'($urandom) : fl(k == 0), op ? fl(k == 0) : 32'($urandom), $urandom,
              1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
